// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// CHECK exists only when IMEM_BOOT_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
`ifdef IMEM_BOOT_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } loader_state_e;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = host/memory side, slave = the loader itself.
interface imem_boot_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8
) ();

    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// Little-endian 4-byte word assembler; word_valid_o fires combinationally with
// the byte that completes a word, and word_o presents that completed word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam int unsigned IdxW = $clog2(BYTES_PER_WORD);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES_PER_WORD - 1);

    logic [IdxW-1:0] idx_q, idx_d;
    logic [23:0]     lo_q, lo_d;

    always_comb begin
        idx_d = idx_q;
        lo_d  = lo_q;
        if (byte_valid_i) begin
            idx_d = idx_q + 1'b1;
            // The final byte bypasses storage and goes straight onto word_o.
            if (idx_q != LastIdx) begin
                lo_d[{idx_q, 3'b000} +: 8] = byte_data_i;
            end
        end
    end

    assign word_valid_o = byte_valid_i && (idx_q == LastIdx);
    assign word_o       = {byte_data_i, lo_q};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q <= '0;
            lo_q  <= '0;
        end else begin
            idx_q <= idx_d;
            lo_q  <= lo_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: header + payload byte stream -> instruction-memory writes.
// Optional trailing checksum byte when IMEM_BOOT_CHECKSUM_EN is defined.
module imem_boot_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    imem_boot_loader_if.slave   bus,
    output logic                done,
    output logic                error,
    output logic                core_reset
);

`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam loader_state_e PostDataState = CHECK;
`else
    localparam loader_state_e PostDataState = DONE;
`endif

    loader_state_e         state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            chk_total;
`endif

    logic        accept;
    logic        word_valid;
    logic [31:0] word;
    logic [15:0] hdr_count;
    logic [15:0] word_next;

    assign accept    = bus.rx_valid && bus.rx_ready;
    assign hdr_count = {bus.rx_data, count_q[7:0]};
    assign word_next = 16'(word_cnt_q) + 16'd1;
`ifdef IMEM_BOOT_CHECKSUM_EN
    assign chk_total = sum_q + bus.rx_data;
`endif

    byte_packer u_packer (
        .clk_i        (clk),
        .reset_i      (reset),
        .byte_valid_i (accept && (state_q == DATA)),
        .byte_data_i  (bus.rx_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        unique case (state_q)
            HDR_LO: begin
                if (accept) begin
                    count_d[7:0] = bus.rx_data;
                    state_d      = HDR_HI;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    count_d = hdr_count;
                    // Bounding N here is what keeps the word index from wrapping.
                    if (32'(hdr_count) > (32'd1 << ADDR_WIDTH)) begin
                        state_d = ERROR;
                    end else if (hdr_count == 16'd0) begin
                        state_d = PostDataState;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                    sum_d = sum_q + bus.rx_data;
`endif
                    if (word_valid) begin
                        we_d       = 1'b1;
                        addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
                        wdata_d    = word;
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (word_next == count_q) begin
                            state_d = PostDataState;
                        end
                    end
                end
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    state_d = (chk_total == 8'd0) ? DONE : ERROR;
                end
            end
`endif
            DONE:    ;
            ERROR:   ;
            default: state_d = ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HDR_LO;
            count_q    <= '0;
            word_cnt_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign bus.rx_ready   = (state_q != DONE) && (state_q != ERROR);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign done           = (state_q == DONE);
    assign error          = (state_q == ERROR);
    assign core_reset     = reset || !done;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboarded directed bench for imem_boot_loader; exercises checksum cases
// when IMEM_BOOT_CHECKSUM_EN is defined.
module tb_imem_boot_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic reset;
    logic done;
    logic error;
    logic core_reset;

    int   checks;
    int   errors;
    int   wr_count;
    logic [7:0] sum;
    wr_t  exp_q[$];

    imem_boot_loader_if #(.ADDR_WIDTH(8)) bus ();

    imem_boot_loader #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .done       (done),
        .error      (error),
        .core_reset (core_reset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the oldest expected write.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_t e;
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%08h expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.imem_addr !== e.addr || bus.imem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr=%0h data=%08h expected addr=%0h data=%08h",
                             bus.imem_addr, bus.imem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        sum          = sum + b;
        @(posedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] lo, input logic [7:0] hi);
        send_byte(lo);
        send_byte(hi);
        sum = 8'd0;
    endtask

    // Checksum byte (if built in), then park at the negedge after the last accept.
    task automatic send_tail();
`ifdef IMEM_BOOT_CHECKSUM_EN
        send_byte(8'd0 - sum);
`endif
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int w0;
        checks       = 0;
        errors       = 0;
        wr_count     = 0;
        sum          = 8'd0;
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("reset_rx_ready", 32'(bus.rx_ready), 32'd1);
        chk("reset_we", 32'(bus.imem_we), 32'd0);
        chk("reset_addr", 32'(bus.imem_addr), 32'd0);
        chk("reset_wdata", bus.imem_wdata, 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_error", 32'(error), 32'd0);
        chk("reset_core_reset", 32'(core_reset), 32'd1);

        // Two-word program.
        push(8'd0, 32'h0000_0013);
        push(8'd1, 32'h0010_0093);
        send_hdr(8'h02, 8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_tail();
        chk("two_word_done", 32'(done), 32'd1);
        chk("two_word_error", 32'(error), 32'd0);
        chk("two_word_core_reset", 32'(core_reset), 32'd0);
        chk("two_word_rx_ready", 32'(bus.rx_ready), 32'd0);
`ifndef IMEM_BOOT_CHECKSUM_EN
        chk("two_word_we_with_done", 32'(bus.imem_we), 32'd1);
`endif
        @(negedge clk);
        chk("two_word_done_sticky", 32'(done), 32'd1);
        chk("two_word_we_one_cycle", 32'(bus.imem_we), 32'd0);
        do_reset();
        chk("post_reset_done", 32'(done), 32'd0);
        chk("post_reset_core_reset", 32'(core_reset), 32'd1);
        chk("post_reset_rx_ready", 32'(bus.rx_ready), 32'd1);

        // Count 0x0101 exceeds the 256-word memory.
        send_byte(8'h01);
        send_byte(8'h01);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("oversize_error", 32'(error), 32'd1);
        chk("oversize_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("oversize_done", 32'(done), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'(8'h40 + i);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("oversize_error_sticky", 32'(error), 32'd1);
        do_reset();

        // Empty image.
        send_hdr(8'h00, 8'h00);
        send_tail();
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_core_reset", 32'(core_reset), 32'd0);
        chk("empty_error", 32'(error), 32'd0);
        do_reset();

        // Stall of 5 cycles between payload bytes 2 and 3.
        push(8'd0, 32'h0000_0013);
        send_hdr(8'h01, 8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'hEE;
        end
        chk("stall_no_early_we", 32'(bus.imem_we), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        send_tail();
`ifndef IMEM_BOOT_CHECKSUM_EN
        chk("stall_we", 32'(bus.imem_we), 32'd1);
`endif
        chk("stall_done", 32'(done), 32'd1);
        do_reset();

        // Reset after 6 payload bytes, then a full single-word reload.
        push(8'd0, 32'h0000_0013);
        send_hdr(8'h02, 8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00);
        do_reset();
        w0 = wr_count;
        push(8'd0, 32'h0010_0093);
        send_hdr(8'h01, 8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_tail();
        chk("midreset_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("midreset_write_count", 32'(wr_count - w0), 32'd1);
        do_reset();

`ifdef IMEM_BOOT_CHECKSUM_EN
        // 01+02+03+04 = 0x0A; 0x0A + 0xF6 = 0x100 -> good.
        push(8'd0, 32'h0403_0201);
        send_hdr(8'h01, 8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hF6);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("csum_good_done", 32'(done), 32'd1);
        chk("csum_good_error", 32'(error), 32'd0);
        do_reset();

        push(8'd0, 32'h0403_0201);
        send_hdr(8'h01, 8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hF7);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("csum_bad_error", 32'(error), 32'd1);
        chk("csum_bad_done", 32'(done), 32'd0);
        do_reset();
`endif

        // Full-depth image: N = 256, last write lands at address 0xFF.
        send_hdr(8'h00, 8'h01);
        for (int i = 0; i < 256; i++) begin
            push(8'(i), {8'hA5, 8'h5A, 8'(i) ^ 8'hFF, 8'(i)});
            send_byte(8'(i));
            send_byte(8'(i) ^ 8'hFF);
            send_byte(8'h5A);
            send_byte(8'hA5);
        end
        send_tail();
        chk("full_done", 32'(done), 32'd1);
        chk("full_error", 32'(error), 32'd0);
        chk("full_last_addr", 32'(bus.imem_addr), 32'h0000_00FF);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
